// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32I data-memory responder with fixed response latency
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  func3_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        e_we;
  logic [31:0] e_addr;
  logic [2:0]  e_func3;
  logic [31:0] e_wdata;
  logic [AW-1:0] idx;
  logic        err_nx;
  logic [31:0] rword;
  logic [31:0] shifted;
  logic [15:0] half;
  logic [31:0] rdata_nx;
  logic [31:0] wword;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // With LATENCY == 1 the storage access happens on the accept edge itself,
  // so the live request is used in IDLE and the captured copy otherwise.
  assign e_we    = (state == IDLE) ? req_we    : we_q;
  assign e_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign e_func3 = (state == IDLE) ? req_func3 : func3_q;
  assign e_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign idx     = e_addr[AW+1:2];

  assign enter_resp = ((state == IDLE) && accept && (LATENCY == 1)) ||
                      ((state == BUSY) && (cnt == 4'd0));

  // Next-state and latency counter
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nx = RESP;
          end else begin
            state_nx = BUSY;
            cnt_nx   = 4'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Error decode, load extraction/extension and store lane merge
  always_comb begin
    err_nx   = 1'b0;
    rdata_nx = 32'd0;
    rword    = mem[idx];
    wword    = rword;
    shifted  = rword >> {e_addr[1:0], 3'b000};
    half     = e_addr[1] ? rword[31:16] : rword[15:0];
    case (e_func3)
      3'b000: begin
        rdata_nx = {{24{shifted[7]}}, shifted[7:0]};
        wword[{e_addr[1:0], 3'b000} +: 8] = e_wdata[7:0];
      end
      3'b001: begin
        err_nx   = e_addr[0];
        rdata_nx = {{16{half[15]}}, half};
        wword[{e_addr[1], 4'b0000} +: 16] = e_wdata[15:0];
      end
      3'b010: begin
        err_nx   = (e_addr[1:0] != 2'b00);
        rdata_nx = rword;
        wword    = e_wdata;
      end
      3'b100: begin
        err_nx   = e_we;
        rdata_nx = {24'd0, shifted[7:0]};
      end
      3'b101: begin
        err_nx   = e_we || e_addr[0];
        rdata_nx = {16'd0, half};
      end
      default: err_nx = 1'b1;
    endcase
    if ({2'b00, e_addr[31:2]} >= 32'(DEPTH_WORDS)) err_nx = 1'b1;
    if (err_nx || e_we) rdata_nx = 32'd0;
  end

  // State, counter, request capture and registered response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      func3_q   <= 3'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        func3_q <= req_func3;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        rsp_rdata <= rdata_nx;
        rsp_err   <= err_nx;
      end
    end
  end

  // Storage write on the RESP entry edge; contents survive reset
  always_ff @(posedge clk) begin
    if (reset_n && enter_resp && e_we && !err_nx) mem[idx] <= wword;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset_n   [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [2:0]  req_func3 [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] mm [16];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_func3(req_func3[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) dut4 (
    .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_func3(req_func3[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request/response with rsp_ready held high; lat counts cycles
  // from the accept edge to the first cycle rsp_valid is seen high.
  task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat);
    int w;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a;
    req_func3[d] = f3;   req_wdata[d] = wd; rsp_ready[d] = 1'b1;
    w = 0;
    while (!req_ready[d] && w < 40) begin @(negedge clk); w++; end
    if (!req_ready[d]) chk("req_ready_timeout", 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(posedge clk); #1;
  endtask

  // Reference: expected response and storage update from the RV32I rules
  function automatic void model(input bit we, input logic [31:0] a, input logic [2:0] f3,
                                input logic [31:0] wd, output logic er, output logic [31:0] rd);
    int sz;
    int off;
    logic [31:0] w, v, mask;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    er = (sz == 0) || (we && f3 > 3'd2) || (a / 4 >= DEPTH);
    if (sz != 0 && (a % sz) != 0) er = 1'b1;
    rd = 32'd0;
    if (!er) begin
      w = mm[a / 4];
      off = int'(a % 4);
      if (we) begin
        for (int k = 0; k < sz; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
        mm[a / 4] = w;
      end else begin
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
        v = (w >> (8*off)) & mask;
        if (f3 < 3'd2 && v[8*sz-1]) v = v | ~mask;
        rd = v;
      end
    end
  endfunction

  initial begin
    logic [31:0] rd, held, a, wd, erd;
    logic        er, eer;
    logic [2:0]  f3;
    bit          we;
    int          lat;

    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
      req_func3[d] = 3'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("rst_rsp_err",   32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;

    // store then load word
    txn(0, 1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_err", 32'(er), 32'd0);
    txn(0, 0, 32'h10, 3'b010, 32'd0, rd, er, lat);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);

    // byte lanes and extension
    txn(0, 1, 32'h20, 3'b010, 32'h0, rd, er, lat);
    txn(0, 1, 32'h21, 3'b000, 32'h12345680, rd, er, lat);
    chk("sb_err", 32'(er), 32'd0);
    txn(0, 0, 32'h21, 3'b000, 32'd0, rd, er, lat);
    chk("lb", rd, 32'hFFFFFF80);
    txn(0, 0, 32'h21, 3'b100, 32'd0, rd, er, lat);
    chk("lbu", rd, 32'h00000080);
    txn(0, 0, 32'h20, 3'b010, 32'd0, rd, er, lat);
    chk("lw_lane", rd, 32'h00008000);
    txn(0, 0, 32'h20, 3'b001, 32'd0, rd, er, lat);
    chk("lh", rd, 32'hFFFF8000);

    // misalignment
    txn(0, 1, 32'h10, 3'b010, 32'h11111111, rd, er, lat);
    txn(0, 0, 32'h13, 3'b001, 32'd0, rd, er, lat);
    chk("lh_mis_err", 32'(er), 32'd1);
    chk("lh_mis_rdata", rd, 32'd0);
    txn(0, 1, 32'h11, 3'b001, 32'hAAAA, rd, er, lat);
    chk("sh_mis_err", 32'(er), 32'd1);
    chk("sh_mis_rdata", rd, 32'd0);
    txn(0, 0, 32'h12, 3'b010, 32'd0, rd, er, lat);
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
    txn(0, 0, 32'h10, 3'b010, 32'd0, rd, er, lat);
    chk("lw_nowrite", rd, 32'h11111111);

    // range and illegal func3
    txn(0, 0, 32'h1000, 3'b010, 32'd0, rd, er, lat);
    chk("range_err", 32'(er), 32'd1);
    chk("range_lat", 32'(lat), 32'd2);
    txn(0, 0, 32'h10, 3'b011, 32'd0, rd, er, lat);
    chk("ld_f3_err", 32'(er), 32'd1);
    txn(0, 1, 32'h10, 3'b100, 32'h5555, rd, er, lat);
    chk("st_f3_err", 32'(er), 32'd1);
    chk("st_f3_lat", 32'(lat), 32'd2);

    // backpressure with a second request waiting
    txn(0, 1, 32'h40, 3'b010, 32'hCAFE0001, rd, er, lat);
    txn(0, 1, 32'h44, 3'b010, 32'h0BADF00D, rd, er, lat);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h40; req_func3[0] = 3'b010;
    rsp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_addr[0] = 32'h44;
    lat = 1;
    while (!rsp_valid[0] && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp_lat", 32'(lat), 32'd2);
    held = rsp_rdata[0];
    chk("bp_rdata", held, 32'hCAFE0001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", 32'(rsp_valid[0]), 32'd1);
      chk("bp_rdata_hold", rsp_rdata[0], held);
      chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_back", 32'(req_ready[0]), 32'd1);
    chk("bp_valid_drop", 32'(rsp_valid[0]), 32'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("bp_second_accept", 32'(req_ready[0]), 32'd0);
    lat = 1;
    while (!rsp_valid[0] && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp2_lat", 32'(lat), 32'd2);
    chk("bp2_rdata", rsp_rdata[0], 32'h0BADF00D);
    @(posedge clk); #1;

    // reset in BUSY on the LATENCY=4 instance
    txn(1, 1, 32'h30, 3'b010, 32'h7, rd, er, lat);
    chk("l4_lat", 32'(lat), 32'd4);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h30;
    req_func3[1] = 3'b010; req_wdata[1] = 32'h5;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("l4_busy_nv", 32'(rsp_valid[1]), 32'd0);
    @(posedge clk); #1;
    reset_n[1] = 1'b0;
    #1;
    chk("l4_rst_ready", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    reset_n[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("l4_no_valid", 32'(rsp_valid[1]), 32'd0);
    end
    chk("l4_ready_after", 32'(req_ready[1]), 32'd1);
    txn(1, 0, 32'h30, 3'b010, 32'd0, rd, er, lat);
    chk("l4_old_value", rd, 32'h7);

    // randomized traffic against the reference model
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model(1, 32'(4*i), 3'b010, wd, eer, erd);
      txn(0, 1, 32'(4*i), 3'b010, wd, rd, er, lat);
    end
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                       : 3'($urandom_range(0, 4) == 3 ? 5 : $urandom_range(0, 4));
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + 32'($urandom_range(0, 63));
        1:       a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, 63));
      endcase
      wd = $urandom;
      model(we, a, f3, wd, eer, erd);
      txn(0, we, a, f3, wd, rd, er, lat);
      chk("rnd_rdata", rd, erd);
      chk("rnd_err", 32'(er), 32'(eer));
      chk("rnd_lat", 32'(lat), 32'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
